// File: rtl/uart_recv_fifo.sv
// UART receiver (configurable divisor, data width, parity) feeding a first-word-fall-through FIFO.
// Define UART_RECV_BRK_DET_EN to classify all-zero frames with a low stop bit as a break (brk pulse, BRKW state).
module uart_recv_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             din,
  input  logic                             ready,
  output logic [7:0]                       data,
  output logic                             valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
  output logic                             frame_err,
  output logic                             parity_err,
  output logic                             overflow,
  output logic                             brk
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] HALF_T = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_T = CW'(DIV - 1);
  localparam logic [2:0]    LAST_B = 3'(DATA_BITS - 1);

`ifdef UART_RECV_BRK_DET_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRKW} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`endif

  state_t          state;
  logic            s1, s, s_d;
  logic [2:0]      fill;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      sh;
  logic            bad;
  logic            par_exp;
  logic            push, pop, full, do_push;
  logic [AW-1:0]   wptr, rptr, rptr_nx;
  logic [7:0]      mem [FIFO_DEPTH];

  // fill gates start detection until s_d reflects a real din sample,
  // so a line held low through reset is not mistaken for a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s    <= 1'b1;
      s_d  <= 1'b1;
      fill <= '0;
    end else begin
      s1   <= din;
      s    <= s1;
      s_d  <= s;
      fill <= {fill[1:0], 1'b1};
    end
  end

  assign par_exp = (PARITY == 2) ? ^sh : ~^sh;
  assign push    = (state == STOP) && (cnt == FULL_T) && s && !bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      bad        <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RECV_BRK_DET_EN
      brk        <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RECV_BRK_DET_EN
      brk        <= 1'b0;
`endif
      case (state)
        IDLE: if (fill[2] && s_d && !s) begin
          cnt   <= '0;
          state <= START;
        end
        START: if (cnt == HALF_T) begin
          cnt <= '0;
          if (!s) begin
            state   <= DATA;
            bit_cnt <= '0;
            sh      <= '0;
            bad     <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == FULL_T) begin
          cnt         <= '0;
          sh[bit_cnt] <= s;
          bit_cnt     <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_B) state <= (PARITY != 0) ? PAR : STOP;
        end else cnt <= cnt + 1'b1;
        PAR: if (cnt == FULL_T) begin
          cnt   <= '0;
          bad   <= (s != par_exp);
          state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (cnt == FULL_T) begin
          cnt   <= '0;
          state <= IDLE;
          if (!s) begin
`ifdef UART_RECV_BRK_DET_EN
            if (sh == 8'h00) begin
              brk   <= 1'b1;
              state <= BRKW;
            end else frame_err <= 1'b1;
`else
            frame_err <= 1'b1;
`endif
          end else if (bad) parity_err <= 1'b1;
        end else cnt <= cnt + 1'b1;
`ifdef UART_RECV_BRK_DET_EN
        BRKW: if (s) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RECV_BRK_DET_EN
  assign brk = 1'b0;
`endif

  assign valid   = (count != '0);
  assign full    = (count == NW'(FIFO_DEPTH));
  assign pop     = valid && ready;
  assign do_push = push && (!full || pop);
  assign rptr_nx = rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= sh;
  end

  // data is a registered head copy so it resets to 0 and holds when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      data     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr_nx;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      if (pop && count > NW'(1))                                data <= mem[rptr_nx];
      else if (do_push && (count == '0 || (pop && count == NW'(1)))) data <= sh;
    end
  end
endmodule

// File: doc/uart_recv_fifo.md
Name: uart_recv_fifo

Overview:
Parametrised UART receiver with a built-in receive FIFO. It replaces the fixed 8N1 receiver and adds configurable baud rate, data width and parity. Received bytes are buffered and handed out over a valid/ready handshake, so a downstream consumer such as the display controller can stall without losing data. Framing, parity and overflow errors are reported as pulses.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD, 115200, line bit rate. DIV = CLK_FREQ/BAUD is the integer number of clocks per bit, and DIV must be ≥ 4.
DATA_BITS, 8, data bits per frame, legal range 5..8, sent LSB first.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
FIFO_DEPTH, 16, number of FIFO entries; must be a power of 2 and ≥ 2.

Ports:
clk  input  1  system clock.
rst  input  1  reset; synchronous, active-high.
din  input  1  asynchronous UART serial input; idles high.
ready  input  1  consumer accepts the head entry when valid && ready.
data  output  8  FIFO head byte; bits [7:DATA_BITS] are 0.
valid  output  1  FIFO is non-empty.
count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
frame_err  output  1  one-cycle pulse when a stop bit is sampled as 0.
parity_err  output  1  one-cycle pulse when the parity check fails.
overflow  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.
brk  output  1  one-cycle pulse on break detection; tied 0 when the feature is compiled out.

Behaviour:
- Input synchroniser: two flops on din, both reset to 1. All FSM decisions use the synchronised value s and its one-cycle-delayed copy s_d.
- Reset state: FSM in IDLE, bit counter = 0, FIFO empty. Outputs reset to data=0, valid=0, count=0, and frame_err=parity_err=overflow=brk=0.
- Reset mid-frame: the partial frame is discarded; there is no residual write and no error pulse.
- FSM states: IDLE, START, DATA, PAR, STOP (plus BRKW when the optional feature is enabled).
  - IDLE: a start is detected on s_d==1 && s==0. The bit counter clears and the FSM goes to START. A line held low through reset never starts a frame.
  - START: at counter DIV/2-1, sample s. If s==0, go to DATA and clear the counter. If s==1, treat it as a glitch and return to IDLE with no pulse.
  - DATA: sample each bit at counter DIV-1 into the shift register, LSB first. After DATA_BITS samples, go to PAR if PARITY!=0, otherwise go to STOP.
  - PAR: sample at DIV-1. The expected bit is the XOR of the data bits for even parity, or its inverse for odd parity. A mismatch sets an internal bad flag.
  - STOP: sample at DIV-1, which is mid-stop-bit, then return to IDLE the same cycle.
    - If s==0: pulse frame_err. frame_err takes precedence over parity_err.
    - Else if the bad flag is set: pulse parity_err.
    - Otherwise: issue a push of the byte.
  - Errored frames are never written. The receiver samples only one stop bit.
- Pulse timing: all pulses assert in the cycle after the stop sample.
- FIFO behaviour: first-word-fall-through.
  - A push into an empty FIFO makes valid=1 with the byte on data one cycle after the stop sample.
  - A pop on valid && ready advances the head in the next cycle.
  - Push while full and no pop in the same cycle: the byte is dropped, overflow pulses, and count is unchanged.
  - Push and pop in the same cycle: both are performed and count is unchanged, including when the FIFO is full. In the full case there is no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
  - When the FIFO is empty, data holds its last value; consumers qualify data with valid.

Optional Feature:
Macro: UART_RECV_BRK_DET_EN.
- Defined: a frame with all data bits 0 and stop sampled 0 (with parity ignored) is classified as a break.
  - brk pulses instead of frame_err, and nothing is written.
  - The FSM enters BRKW and stays there until s==1, then goes to IDLE.
- Undefined: BRKW and its logic are absent and brk is constant 0. The same frame is reported as a frame_err.

Test Plan:
Default parameters (DIV=868). Send 0x55 as 8N1 → valid=1, data=0x55, count=1 one cycle after the stop sample. Pop with ready=1 → valid=0, count=0.
din low for 300 clocks, then high → no pulse, count=0, and a following frame 0xA3 is received correctly.
FIFO_DEPTH=4, ready=0, send 0x01..0x05 → count=4 and overflow pulses once on the 5th frame. Then ready=1 → data sequence 01,02,03,04.
PARITY=2, send 0xA5 with parity bit 1 (wrong) → parity_err pulse, count=0. Resend with parity bit 0 → data=0xA5.
Send 0x3C with stop bit 0 → frame_err pulse and nothing stored. With UART_RECV_BRK_DET_EN defined, hold din low for 20 bit times → brk pulses once, with no frame_err.
Assert rst after 4 data bits of 0xFF → all outputs 0. Then send 0x7E → data=0x7E, valid=1.
